// File: rtl/cond_branch_unit_pkg.sv
// Shared definitions for the conditional branch unit: condition codes,
// flag bit positions within {N,Z,C,V}, and the branch FSM state encoding.
package cond_branch_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

endpackage

// File: rtl/cond_branch_unit_cond_decode.sv
// Condition evaluator: maps a {N,Z,C,V} flag word and condition code to a decision.
// Latency: purely combinational. Backpressure: none.
// Reuse: stateless, safe to share between pipeline stages.
module cond_decode
    import cond_branch_unit_pkg::*;
(
    input  logic [3:0] flags,
    input  cond_t      cond,
    output logic       take
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_MI: take = n;
            COND_PL: take = !n;
            COND_VS: take = v;
            COND_VC: take = !v;
            COND_HI: take = c && !z;
            COND_LS: take = !c || z;
            COND_GE: take = (n == v);
            COND_LT: take = (n != v);
            COND_GT: take = !z && (n == v);
            COND_LE: take = z || (n != v);
            COND_AL: take = 1'b1;
            COND_NV: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// Branch resolver: holds ALU flags, decides one branch at a time; optional STICKY_OVF_EN adds so_flag.
// Latency: decision strobe 1 cycle after accept, or 1 cycle after the awaited flag write.
// Backpressure: br_ready is low from accept until the decision strobe has been issued.
module cond_branch_unit
    import cond_branch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic [31:0] res,
    input  logic        res_c,
    input  logic        res_v,
    input  logic        set_flags,
    input  logic        flags_pending,
    input  logic        br_valid,
    input  logic [3:0]  br_cond,
`ifdef STICKY_OVF_EN
    input  logic        clr_so,
    output logic        so_flag,
`endif
    output logic        br_ready,
    output logic        take_valid,
    output logic        take,
    output logic [3:0]  flags
);

    state_t state;
    cond_t  cond_q;
    logic   flag_wr;
    logic   dec_take;

    assign flag_wr = res_valid && set_flags;

    // Flags update regardless of FSM state so a branch always sees the newest result.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (flag_wr) begin
            flags[FLAG_N] <= res[31];
            flags[FLAG_Z] <= (res == 32'h0);
            flags[FLAG_C] <= res_c;
            flags[FLAG_V] <= res_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cond_q     <= COND_EQ;
            br_ready   <= 1'b1;
            take_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (br_valid && br_ready) begin
                        cond_q   <= cond_t'(br_cond);
                        br_ready <= 1'b0;
                        if (flags_pending) begin
                            state <= WAIT;
                        end else begin
                            state      <= RESOLVE;
                            take_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (flag_wr) begin
                        state      <= RESOLVE;
                        take_valid <= 1'b1;
                    end
                end
                RESOLVE: begin
                    state      <= IDLE;
                    take_valid <= 1'b0;
                    br_ready   <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    take_valid <= 1'b0;
                    br_ready   <= 1'b1;
                end
            endcase
        end
    end

    cond_decode u_cond_decode (
        .flags (flags),
        .cond  (cond_q),
        .take  (dec_take)
    );

    // Evaluated from the registered flags during RESOLVE, forced low otherwise.
    assign take = take_valid && dec_take;

`ifdef STICKY_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            so_flag <= 1'b0;
        end else if (flag_wr && res_v) begin
            so_flag <= 1'b1;
        end else if (clr_so) begin
            so_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cond_branch_unit.sv
// Bench for cond_branch_unit: directed vector table, multi-cycle corner sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_cond_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [31:0] res;
    logic        res_c;
    logic        res_v;
    logic        set_flags;
    logic        flags_pending;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic        br_ready;
    logic        take_valid;
    logic        take;
    logic [3:0]  flags;
`ifdef STICKY_OVF_EN
    logic        clr_so;
    logic        so_flag;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cond_branch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .res_valid     (res_valid),
        .res           (res),
        .res_c         (res_c),
        .res_v         (res_v),
        .set_flags     (set_flags),
        .flags_pending (flags_pending),
        .br_valid      (br_valid),
        .br_cond       (br_cond),
`ifdef STICKY_OVF_EN
        .clr_so        (clr_so),
        .so_flag       (so_flag),
`endif
        .br_ready      (br_ready),
        .take_valid    (take_valid),
        .take          (take),
        .flags         (flags)
    );

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic [3:0]  cond;
        logic [3:0]  exp_flags;
        logic        exp_take;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        res_valid     = 1'b0;
        set_flags     = 1'b0;
        res           = 32'h0;
        res_c         = 1'b0;
        res_v         = 1'b0;
        flags_pending = 1'b0;
        br_valid      = 1'b0;
        br_cond       = 4'h0;
`ifdef STICKY_OVF_EN
        clr_so        = 1'b0;
`endif
    endtask

    task automatic write_flags(input logic [31:0] r, input logic c, input logic v);
        res_valid = 1'b1;
        set_flags = 1'b1;
        res       = r;
        res_c     = c;
        res_v     = v;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reference condition semantics, written from the N/Z/C/V meaning of each code.
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        logic signed_lt;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        signed_lt = n ^ v;
        case (code)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !(c && !z);
            4'hA: return !signed_lt;
            4'hB: return signed_lt;
            4'hC: return !z && !signed_lt;
            4'hD: return !(!z && !signed_lt);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input logic [31:0] r, input logic c, input logic v);
        return {r[31], (r == 32'h0), c, v};
    endfunction

    // Random-run model state: one outstanding branch with a known or pending decision cycle.
    logic [3:0] m_flags;
    logic       m_outst;
    logic [3:0] m_cond;
    int         m_decide_at;
    logic       m_held;

    initial begin
        rst = 1'b0;
        idle_in();

        vecs[0]  = '{32'h0000_0000, 1'b1, 1'b0, 4'h0, 4'b0110, 1'b1};
        vecs[1]  = '{32'h8000_0000, 1'b0, 1'b0, 4'hB, 4'b1000, 1'b1};
        vecs[2]  = '{32'h8000_0000, 1'b0, 1'b0, 4'hA, 4'b1000, 1'b0};
        vecs[3]  = '{32'h0000_0005, 1'b0, 1'b0, 4'h1, 4'b0000, 1'b1};
        vecs[4]  = '{32'h0000_0005, 1'b1, 1'b0, 4'h2, 4'b0010, 1'b1};
        vecs[5]  = '{32'h0000_0005, 1'b1, 1'b0, 4'h3, 4'b0010, 1'b0};
        vecs[6]  = '{32'h8000_0000, 1'b0, 1'b0, 4'h4, 4'b1000, 1'b1};
        vecs[7]  = '{32'h0000_0001, 1'b0, 1'b0, 4'h5, 4'b0000, 1'b1};
        vecs[8]  = '{32'h0000_0001, 1'b0, 1'b1, 4'h6, 4'b0001, 1'b1};
        vecs[9]  = '{32'h0000_0001, 1'b0, 1'b1, 4'h7, 4'b0001, 1'b0};
        vecs[10] = '{32'h0000_0007, 1'b1, 1'b0, 4'h8, 4'b0010, 1'b1};
        vecs[11] = '{32'h0000_0000, 1'b1, 1'b0, 4'h8, 4'b0110, 1'b0};
        vecs[12] = '{32'h0000_0000, 1'b0, 1'b0, 4'h9, 4'b0100, 1'b1};
        vecs[13] = '{32'h8000_0001, 1'b0, 1'b1, 4'hC, 4'b1001, 1'b1};
        vecs[14] = '{32'h0000_0000, 1'b0, 1'b0, 4'hC, 4'b0100, 1'b0};
        vecs[15] = '{32'h0000_0002, 1'b0, 1'b1, 4'hD, 4'b0001, 1'b1};
        vecs[16] = '{32'h0000_0002, 1'b0, 1'b0, 4'hD, 4'b0000, 1'b0};
        vecs[17] = '{32'h0000_0003, 1'b0, 1'b0, 4'hE, 4'b0000, 1'b1};
        vecs[18] = '{32'h0000_0000, 1'b1, 1'b1, 4'hF, 4'b0111, 1'b0};
        vecs[19] = '{32'h8000_0001, 1'b0, 1'b1, 4'hB, 4'b1001, 1'b0};

        // Reset state
        do_reset();
        chk("reset_flags", flags, 4'b0000);
        chk("reset_take_valid", take_valid, 1'b0);
        chk("reset_take", take, 1'b0);
        chk("reset_br_ready", br_ready, 1'b1);

        // Flag write and accept in the same cycle: decision uses the new flags.
        for (int i = 0; i < 20; i++) begin
            write_flags(vecs[i].res, vecs[i].c, vecs[i].v);
            br_valid = 1'b1;
            br_cond  = vecs[i].cond;
            step();
            idle_in();
            chk($sformatf("vec%0d_take_valid", i), take_valid, 1'b1);
            chk($sformatf("vec%0d_take", i), take, vecs[i].exp_take);
            chk($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
            chk($sformatf("vec%0d_busy", i), br_ready, 1'b0);
            step();
            chk($sformatf("vec%0d_tv_drop", i), take_valid, 1'b0);
            chk($sformatf("vec%0d_take_drop", i), take, 1'b0);
            chk($sformatf("vec%0d_ready_back", i), br_ready, 1'b1);
        end

        // Pending flags: result arrives 3 cycles after accept, decision one cycle later.
        write_flags(32'h0, 1'b0, 1'b0);
        step();
        idle_in();
        br_valid      = 1'b1;
        br_cond       = 4'h1;
        flags_pending = 1'b1;
        step();
        idle_in();
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("pend_c%0d_ready", k), br_ready, 1'b0);
            chk($sformatf("pend_c%0d_tv", k), take_valid, 1'b0);
            if (k == 3) write_flags(32'h5, 1'b0, 1'b0);
            step();
        end
        idle_in();
        chk("pend_tv", take_valid, 1'b1);
        chk("pend_take", take, 1'b1);
        chk("pend_ready", br_ready, 1'b0);
        chk("pend_flags", flags, 4'b0000);
        step();
        chk("pend_tv_drop", take_valid, 1'b0);
        chk("pend_ready_back", br_ready, 1'b1);

        // br_valid held for two cycles: one accept, the next one only in the following IDLE.
        br_valid = 1'b1;
        br_cond  = 4'hE;
        step();
        chk("hold_tv1", take_valid, 1'b1);
        chk("hold_ready1", br_ready, 1'b0);
        step();
        chk("hold_tv2", take_valid, 1'b0);
        chk("hold_ready2", br_ready, 1'b1);
        step();
        idle_in();
        chk("hold_tv3", take_valid, 1'b1);
        chk("hold_take3", take, 1'b1);
        step();
        chk("hold_ready4", br_ready, 1'b1);

        // Reset while waiting discards the branch.
        write_flags(32'h8000_0000, 1'b1, 1'b1);
        step();
        idle_in();
        br_valid      = 1'b1;
        br_cond       = 4'hE;
        flags_pending = 1'b1;
        step();
        idle_in();
        chk("rstw_in_wait", br_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_flags", flags, 4'b0000);
        chk("rstw_ready", br_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstw_tv%0d", k), take_valid, 1'b0);
            if (k == 0) write_flags(32'h1, 1'b0, 1'b0);
            step();
            idle_in();
        end

`ifdef STICKY_OVF_EN
        do_reset();
        chk("so_reset", so_flag, 1'b0);
        write_flags(32'h1, 1'b0, 1'b1);
        step();
        write_flags(32'h1, 1'b0, 1'b0);
        step();
        idle_in();
        chk("so_sticky", so_flag, 1'b1);
        write_flags(32'h1, 1'b0, 1'b1);
        clr_so = 1'b1;
        step();
        idle_in();
        chk("so_set_wins", so_flag, 1'b1);
        clr_so = 1'b1;
        step();
        idle_in();
        chk("so_clear", so_flag, 1'b0);
`endif

        // Randomized run against the transaction-level model.
        do_reset();
        m_flags     = 4'b0000;
        m_outst     = 1'b0;
        m_cond      = 4'h0;
        m_decide_at = -1;
        m_held      = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic exp_tv, exp_rdy, exp_take, fw;
            exp_rdy  = !m_outst;
            exp_tv   = m_outst && (m_decide_at == cyc);
            exp_take = exp_tv ? ref_cond(m_cond, m_flags) : 1'b0;
            chk("rnd_ready", br_ready, exp_rdy);
            chk("rnd_tv", take_valid, exp_tv);
            chk("rnd_take", take, exp_take);
            chk("rnd_flags", flags, m_flags);

            res_valid     = ($urandom_range(0, 2) == 0);
            set_flags     = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 3))
                0:       res = 32'h0;
                1:       res = 32'h8000_0000;
                default: res = $urandom;
            endcase
            res_c         = $urandom_range(0, 1) == 1;
            res_v         = $urandom_range(0, 1) == 1;
            flags_pending = $urandom_range(0, 1) == 1;
            if (!m_held) begin
                br_valid = ($urandom_range(0, 2) == 0);
                br_cond  = 4'($urandom_range(0, 15));
            end
            fw = res_valid && set_flags;

            if (exp_tv) begin
                m_outst = 1'b0;
            end else if (m_outst && m_decide_at < 0 && fw) begin
                m_decide_at = cyc + 1;
            end
            if (exp_rdy && br_valid) begin
                m_outst     = 1'b1;
                m_cond      = br_cond;
                m_decide_at = flags_pending ? -1 : cyc + 1;
                m_held      = 1'b0;
            end else begin
                m_held = br_valid;
            end
            if (fw) m_flags = ref_flags(res, res_c, res_v);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
